ycr1_icache_sched: RTL
======================

# ycr1_icache_sched

Sequential two-master scheduler sharing the single instruction-cache port between the core imem and dmem request interfaces. It sits between the pipeline memory interfaces and the icache. It arbitrates round-robin and holds ownership from grant until the burst's terminal response. It converts the cache's last-beat code to a plain OK for the core and, optionally, aborts hung transactions with a watchdog.

## Interface
- `TMO_W`, 8: watchdog counter width.
- `TMO_CYCLES`, 255: idle cycles without a response beat before abort; must be < 2^TMO_W.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `imem_req`, `imem_cmd`, `imem_width[1:0]`, `imem_addr[YCR1_IMEM_AWIDTH]`, `imem_bl[YCR1_IMEM_BSIZE]`  in: imem request.
- `imem_req_ack`  out  1; `imem_rdata`  out  YCR1_IMEM_DWIDTH; `imem_resp`  out  2.
- `dmem_req`, `dmem_cmd`, `dmem_width[1:0]`, `dmem_addr[YCR1_DMEM_AWIDTH]`  in: dmem request; burst length forced to 1.
- `dmem_req_ack`  out  1; `dmem_rdata`  out  YCR1_DMEM_DWIDTH; `dmem_resp`  out  2.
- `icache_req`, `icache_cmd`, `icache_width[1:0]`, `icache_addr`, `icache_bl`  out: forwarded request of owner.
- `icache_req_ack`  in  1; `icache_rdata`  in  YCR1_IMEM_DWIDTH; `icache_resp`  in  2.
- `sched_tmo`  out  1: one-cycle pulse on watchdog abort.

## Operation
- Response codes: 0 NOTRDY, 1 RDY_OK, 2 RDY_ER, 3 RDY_LOK. Terminal = 2 or 3.
- States: IDLE, GNT_I, GNT_D, DRAIN. Registered `last` pointer (0 = imem served last) and `accepted` flag.
- IDLE: with one request pending, go to that GNT state. With both pending, grant the master not named by `last`. With none pending, stay.
- GNT_x: forward owner's request fields; other master's outputs held 0.
  - `icache_req_ack` is routed to the owner and sets `accepted`.
  - Owner dropping req while `accepted`=0 returns to IDLE next cycle.
  - On a terminal resp with `accepted`=1:
    - update `last` to the owner;
    - clear `accepted`;
    - re-arbitrate in the same cycle using IDLE rules on the current requests. The next state is GNT_x' directly, giving zero bubble.
- Response mapping to owner: 3 becomes 1; 0, 1 and 2 pass unchanged. `rdata` is passed only to the owner; the non-owner sees rdata 0 and resp 0.
- Watchdog (macro-enabled):
  - the counter clears on grant and on every non-zero `icache_resp`;
  - it increments each GNT cycle with `accepted`=1 and resp 0;
  - at count == TMO_CYCLES: drive owner resp = 2 for that cycle, pulse `sched_tmo`, go to DRAIN.
- DRAIN: no grants, icache_req 0, all core resp 0. Discard icache responses until a terminal one arrives, then go to IDLE.

## Timing
- Reset values: state IDLE, `last`=1 (imem wins first tie), `accepted`=0, counter 0. All outputs 0, including both req_acks, both resps, icache_req and sched_tmo.
- Arbitration latency from IDLE: 1 cycle, request visible at icache the cycle after req rises.
- Output muxes are combinational from the registered state. icache_req_ack → core ack and icache_resp → core resp have zero latency.
- Simultaneous terminal resp and new request from the same master: that master competes under round-robin. It wins only if the other is idle.
- Terminal resp in the same cycle as the watchdog expiry: the terminal resp wins; no abort.
- `rst` mid-burst: return to reset values next edge. The icache is expected to be reset together with the scheduler.

## Configuration
- `YCR1_ICACHE_SCHED_TMO_EN` defined: watchdog counter, DRAIN state and `sched_tmo` generation are present.
- Not defined: counter and DRAIN removed, `sched_tmo` tied 0, ownership held indefinitely until a terminal response.

## Test plan
- Only imem_req, bl=4, icache acks then resp 1,1,1,3 → imem_resp 1,1,1,1; grant returns IDLE after the 4th beat; dmem outputs remain 0.
- Both request from reset → imem granted first. Its terminal resp 3 switches directly to GNT_D the same edge, with no idle cycle, then back to imem.
- dmem request with bl input unused → icache_bl == 1, dmem_resp 3 mapped to 1, last=dmem.
- Owner gets resp 2 mid-burst → passed as 2, ownership released, other master granted next edge.
- TMO_EN, accepted with no resp for 255 cycles → owner resp 2 and sched_tmo pulse at cycle 255, no grants until icache later returns 3, then IDLE.
- Assert rst during GNT_D with accepted=1 → next cycle all outputs 0, state IDLE, first tie goes to imem.

Source files
------------

// File: rtl/ycr1_icache_sched_if.sv
// Request/response port shared by the core imem, core dmem and icache sides of the scheduler.
interface ycr1_icache_sched_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int BSIZE  = 3
);
    logic              req;
    logic              cmd;
    logic [1:0]        width;
    logic [AWIDTH-1:0] addr;
    logic [BSIZE-1:0]  bl;
    logic              req_ack;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        resp;

    modport master (output req, cmd, width, addr, bl, input  req_ack, rdata, resp);
    modport slave  (input  req, cmd, width, addr, bl, output req_ack, rdata, resp);
endinterface

// File: rtl/ycr1_icache_sched.sv
// Round-robin scheduler sharing one icache port between core imem and dmem requesters.
// Define YCR1_ICACHE_SCHED_TMO_EN to add the hung-transaction watchdog and DRAIN state.
module ycr1_icache_sched #(
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    ycr1_icache_sched_if.slave  imem,
    ycr1_icache_sched_if.slave  dmem,
    ycr1_icache_sched_if.master icache,
    output logic                sched_tmo
);
    localparam logic [1:0] RESP_NOTRDY = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ER     = 2'd2;
    localparam logic [1:0] RESP_LOK    = 2'd3;

`ifdef YCR1_ICACHE_SCHED_TMO_EN
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_e;
`else
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;
`endif

    state_e     state_q, state_d;
    logic       last_q, last_d;     // 1: dmem was served last, so imem wins a tie
    logic       acc_q, acc_d;
    logic       owner_is_d;
    logic       owner_req;
    logic       terminal;
    logic [1:0] core_resp;
`ifdef YCR1_ICACHE_SCHED_TMO_EN
    logic [TMO_W-1:0] cnt_q, cnt_d;
`endif

    function automatic state_e arbitrate(input logic i_req, input logic d_req, input logic d_last);
        if (i_req && d_req) return d_last ? GNT_I : GNT_D;
        if (i_req)          return GNT_I;
        if (d_req)          return GNT_D;
        return IDLE;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        last_d         = last_q;
        acc_d          = acc_q;
        sched_tmo      = 1'b0;
        icache.req     = 1'b0;
        icache.cmd     = 1'b0;
        icache.width   = '0;
        icache.addr    = '0;
        icache.bl      = '0;
        imem.req_ack   = 1'b0;
        imem.rdata     = '0;
        imem.resp      = RESP_NOTRDY;
        dmem.req_ack   = 1'b0;
        dmem.rdata     = '0;
        dmem.resp      = RESP_NOTRDY;
        owner_is_d     = (state_q == GNT_D);
        owner_req      = owner_is_d ? dmem.req : imem.req;
        terminal       = icache.resp[1];
        core_resp      = (icache.resp == RESP_LOK) ? RESP_OK : icache.resp;

        case (state_q)
            IDLE: state_d = arbitrate(imem.req, dmem.req, last_q);

            GNT_I, GNT_D: begin
                if (owner_is_d) begin
                    icache.req   = dmem.req;
                    icache.cmd   = dmem.cmd;
                    icache.width = dmem.width;
                    icache.addr  = dmem.addr;
                    icache.bl[0] = 1'b1;    // dmem accesses are always single-beat
                end else begin
                    icache.req   = imem.req;
                    icache.cmd   = imem.cmd;
                    icache.width = imem.width;
                    icache.addr  = imem.addr;
                    icache.bl    = imem.bl;
                end

                if (icache.req_ack) acc_d = 1'b1;

                if (acc_q && terminal) begin
                    last_d  = owner_is_d;
                    acc_d   = 1'b0;
                    state_d = arbitrate(imem.req, dmem.req, owner_is_d);
                end else if (!acc_q && !owner_req) begin
                    acc_d   = 1'b0;
                    state_d = IDLE;
                end
`ifdef YCR1_ICACHE_SCHED_TMO_EN
                else if (acc_q && icache.resp == RESP_NOTRDY && cnt_q == TMO_W'(TMO_CYCLES)) begin
                    core_resp = RESP_ER;
                    sched_tmo = 1'b1;
                    acc_d     = 1'b0;
                    state_d   = DRAIN;
                end
`endif

                if (owner_is_d) begin
                    dmem.req_ack = icache.req_ack;
                    dmem.rdata   = icache.rdata;
                    dmem.resp    = core_resp;
                end else begin
                    imem.req_ack = icache.req_ack;
                    imem.rdata   = icache.rdata;
                    imem.resp    = core_resp;
                end
            end

`ifdef YCR1_ICACHE_SCHED_TMO_EN
            // Aborted burst: swallow the cache's remaining beats before granting again.
            DRAIN: if (terminal) state_d = IDLE;
`endif

            default: state_d = IDLE;
        endcase
    end

`ifdef YCR1_ICACHE_SCHED_TMO_EN
    // A grant always follows IDLE or a terminal beat, both of which clear the count.
    always_comb begin
        cnt_d = '0;
        if (state_q == GNT_I || state_q == GNT_D) begin
            if (icache.resp != RESP_NOTRDY) cnt_d = '0;
            else if (acc_q)                 cnt_d = cnt_q + 1'b1;
            else                            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
        end
    end
endmodule
